// File: rtl/mem_defs_pkg.sv
// Shared memory-system definitions used by d_cache, dmem and anything placed
// between them: bus command encoding, address/line widths and memory size.
package mem_defs_pkg;

  localparam int XLEN        = 32;
  localparam int DATA_LENGTH = 64;
  localparam int MEM_SIZE    = 65536;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

endpackage

// File: rtl/victim_buffer_pkg.sv
// Definitions for the victim buffer that sits between d_cache and dmem:
// the reserved buffer-sourced tag, default sizes, line-key width, the
// completion-queue entry layout and a helper to extract a line key.
package victim_buffer_pkg;
  import mem_defs_pkg::*;

  // dmem issues tags 1..14; 15 marks a response produced by the buffer itself.
  localparam logic [3:0] VB_TAG = 4'd15;

  localparam int VB_ENTRIES_DEFAULT = 4;
  localparam int CQ_DEPTH_DEFAULT   = 4;

  // A line is 8 bytes, so the low three address bits do not take part in matching.
  localparam int LINE_KEY_W = XLEN - 3;

  // A load hit is only accepted while fewer than this many completions wait.
  // With one dmem completion and one hit per cycle and one dequeue per cycle,
  // this bounds the queue occupancy at 3.
  localparam int CQ_HIT_LIMIT = 3;

  typedef struct packed {
    logic [3:0]             tag;
    logic [DATA_LENGTH-1:0] data;
  } cq_entry_t;

  function automatic logic [LINE_KEY_W-1:0] line_key(input logic [XLEN-1:0] addr);
    return addr[XLEN-1:3];
  endfunction

endpackage

// File: rtl/vb_completion_queue.sv
// Synchronous FIFO of completion entries {tag, data} with two ordered push
// ports and one pop port. push0 is always written ahead of push1 in a cycle;
// push1 may be used alone. Reports its occupancy on count.
//   clk, rst      : clock, synchronous active-high reset
//   push0_valid/push0_entry : first entry written this cycle
//   push1_valid/push1_entry : second entry written this cycle
//   pop           : remove the head entry (ignored when empty)
//   head          : oldest entry (undefined when count == 0)
//   count         : number of stored entries
module vb_completion_queue
  import victim_buffer_pkg::*;
#(
  parameter int  DEPTH = CQ_DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0_valid,
  input  cq_entry_t        push0_entry,
  input  logic             push1_valid,
  input  cq_entry_t        push1_entry,
  input  logic             pop,
  output cq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  cq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] slot_b;
  logic             pop_eff;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_eff = pop && (count != '0);
  assign slot_b  = push0_valid ? wrap_inc(tail_ptr) : tail_ptr;
  assign head    = mem[head_ptr];

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (pop_eff) head_ptr <= wrap_inc(head_ptr);
      case ({push0_valid, push1_valid})
        2'b11:        tail_ptr <= wrap_inc(wrap_inc(tail_ptr));
        2'b10, 2'b01: tail_ptr <= wrap_inc(tail_ptr);
        default:      tail_ptr <= tail_ptr;
      endcase
      count <= count + CNT_W'(push0_valid) + CNT_W'(push1_valid) - CNT_W'(pop_eff);
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count decide
  // which slots are meaningful, so clearing the data would be wasted logic.
  always_ff @(posedge clk) begin
    if (push0_valid) mem[tail_ptr] <= push0_entry;
    if (push1_valid) mem[slot_b]   <= push1_entry;
  end

endmodule

// File: rtl/victim_buffer.sv
// Victim buffer between d_cache and dmem. Holds evicted (stored) lines in a
// small fully associative FIFO, serves load hits from it with tag VB_TAG,
// forwards load misses to dmem and drains the oldest line to dmem whenever
// the cache is idle or a new victim finds the buffer full. All completions
// (dmem and buffer) return to the cache through a registered queue.
//   clk, rst                         : clock, synchronous active-high reset
//   cache2vb_command/address/data    : request from d_cache
//   vb2cache_response                : same-cycle accept tag, 0 = retry
//   vb2cache_tag/data                : registered completion, tag 0 = none
//   vb2mem_command/address/data      : request to dmem
//   mem2vb_response/tag/data         : dmem accept, completion tag and data
//   vb_hit_counter/vb_miss_counter   : accepted load hits / accepted load misses
module victim_buffer
  import mem_defs_pkg::*, victim_buffer_pkg::*;
#(
  parameter int VB_ENTRIES = VB_ENTRIES_DEFAULT,
  parameter int CQ_DEPTH   = CQ_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cache2vb_command,
  input  logic [XLEN-1:0]        cache2vb_address,
  input  logic [DATA_LENGTH-1:0] cache2vb_data,
  output logic [3:0]             vb2cache_response,
  output logic [3:0]             vb2cache_tag,
  output logic [DATA_LENGTH-1:0] vb2cache_data,
  output logic [1:0]             vb2mem_command,
  output logic [XLEN-1:0]        vb2mem_address,
  output logic [DATA_LENGTH-1:0] vb2mem_data,
  input  logic [3:0]             mem2vb_response,
  input  logic [3:0]             mem2vb_tag,
  input  logic [DATA_LENGTH-1:0] mem2vb_data,
  output integer                 vb_hit_counter,
  output integer                 vb_miss_counter
);

  localparam int PTR_W = (VB_ENTRIES > 1) ? $clog2(VB_ENTRIES) : 1;
  localparam int CNT_W = $clog2(CQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] HIT_LIMIT = CNT_W'(CQ_HIT_LIMIT);

  // Line storage; valid bits and pointers are reset, key/data are not.
  logic [VB_ENTRIES-1:0]  entry_valid;
  logic [LINE_KEY_W-1:0]  entry_key  [VB_ENTRIES];
  logic [DATA_LENGTH-1:0] entry_data [VB_ENTRIES];
  logic [PTR_W-1:0]       head_ptr;
  logic [PTR_W-1:0]       tail_ptr;

  logic                   full;
  logic                   empty;
  logic [LINE_KEY_W-1:0]  req_key;
  logic                   hit;
  logic [PTR_W-1:0]       hit_idx;

  // Per-cycle decisions.
  logic                   hit_accept;
  logic                   store_update;
  logic                   store_alloc;
  logic                   head_pop;
  logic                   miss_accept;

  // Completion path.
  logic [CNT_W-1:0]       cq_count;
  cq_entry_t              cq_head;
  cq_entry_t              hit_entry;
  cq_entry_t              mem_cpl;
  logic                   mem_cpl_valid;
  logic                   cq_pop;
  logic                   cq_push0_valid;
  cq_entry_t              cq_push0;
  logic                   cq_push1_valid;
  cq_entry_t              cq_push1;
  cq_entry_t              out_next;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(VB_ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = &entry_valid;
  assign empty   = ~|entry_valid;
  assign req_key = line_key(cache2vb_address);

  // Store hits overwrite in place, so at most one entry can match a key.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < VB_ENTRIES; i++) begin
      if (entry_valid[i] && (entry_key[i] == req_key)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    vb2cache_response = '0;
    vb2mem_command    = BUS_NONE;
    vb2mem_address    = '0;
    vb2mem_data       = '0;
    hit_accept        = 1'b0;
    store_update      = 1'b0;
    store_alloc       = 1'b0;
    head_pop          = 1'b0;
    miss_accept       = 1'b0;
    if (!rst) begin
      case (cache2vb_command)
        BUS_LOAD: begin
          if (hit) begin
            // Refuse the hit while the completion queue is near capacity.
            if (cq_count < HIT_LIMIT) begin
              vb2cache_response = VB_TAG;
              hit_accept        = 1'b1;
            end
          end else begin
            vb2mem_command    = BUS_LOAD;
            vb2mem_address    = cache2vb_address;
            vb2mem_data       = cache2vb_data;
            vb2cache_response = mem2vb_response;
            miss_accept       = (mem2vb_response != '0);
          end
        end
        BUS_STORE: begin
          if (hit) begin
            vb2cache_response = VB_TAG;
            store_update      = 1'b1;
          end else if (!full) begin
            vb2cache_response = VB_TAG;
            store_alloc       = 1'b1;
          end else begin
            // Make room: write the oldest line back; the cache retries.
            vb2mem_command = BUS_STORE;
            vb2mem_address = {entry_key[head_ptr], 3'b000};
            vb2mem_data    = entry_data[head_ptr];
            head_pop       = (mem2vb_response != '0);
          end
        end
        BUS_NONE: begin
          if (!empty) begin
            vb2mem_command = BUS_STORE;
            vb2mem_address = {entry_key[head_ptr], 3'b000};
            vb2mem_data    = entry_data[head_ptr];
            head_pop       = (mem2vb_response != '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid     <= '0;
      head_ptr        <= '0;
      tail_ptr        <= '0;
      vb_hit_counter  <= 0;
      vb_miss_counter <= 0;
    end else begin
      // Allocation and pop are mutually exclusive (different commands).
      if (store_alloc) begin
        entry_valid[tail_ptr] <= 1'b1;
        tail_ptr              <= wrap_inc(tail_ptr);
      end
      if (head_pop) begin
        entry_valid[head_ptr] <= 1'b0;
        head_ptr              <= wrap_inc(head_ptr);
      end
      if (hit_accept)  vb_hit_counter  <= vb_hit_counter + 1;
      if (miss_accept) vb_miss_counter <= vb_miss_counter + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (store_alloc) begin
      entry_key[tail_ptr]  <= req_key;
      entry_data[tail_ptr] <= cache2vb_data;
    end
    if (store_update) entry_data[hit_idx] <= cache2vb_data;
  end

  // Completion ordering: entries already queued, then this cycle's dmem
  // completion, then this cycle's hit. The first of these is registered to
  // the output and the rest are queued, so an otherwise idle path has
  // one-cycle latency.
  assign hit_entry     = '{tag: VB_TAG, data: entry_data[hit_idx]};
  assign mem_cpl       = '{tag: mem2vb_tag, data: mem2vb_data};
  assign mem_cpl_valid = !rst && (mem2vb_tag != '0);

  always_comb begin
    out_next       = '0;
    cq_pop         = 1'b0;
    cq_push0_valid = 1'b0;
    cq_push0       = mem_cpl;
    cq_push1_valid = 1'b0;
    cq_push1       = hit_entry;
    if (cq_count != '0) begin
      out_next       = cq_head;
      cq_pop         = 1'b1;
      cq_push0_valid = mem_cpl_valid;
      cq_push1_valid = hit_accept;
    end else if (mem_cpl_valid) begin
      out_next       = mem_cpl;
      cq_push0_valid = hit_accept;
      cq_push0       = hit_entry;
    end else if (hit_accept) begin
      out_next = hit_entry;
    end
  end

  vb_completion_queue #(.DEPTH(CQ_DEPTH)) u_cq (
    .clk         (clk),
    .rst         (rst),
    .push0_valid (cq_push0_valid),
    .push0_entry (cq_push0),
    .push1_valid (cq_push1_valid),
    .push1_entry (cq_push1),
    .pop         (cq_pop),
    .head        (cq_head),
    .count       (cq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vb2cache_tag  <= '0;
      vb2cache_data <= '0;
    end else begin
      vb2cache_tag  <= out_next.tag;
      vb2cache_data <= out_next.data;
    end
  end

endmodule

// File: doc/victim_buffer.md
VICTIM_BUFFER -- requirements
Module: victim_buffer

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 cache2vb_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from d_cache.
REQ-004 cache2vb_address  in  XLEN  request address; line key = address[XLEN-1:3].
REQ-005 cache2vb_data  in  DATA_LENGTH  store (victim) line data.
REQ-006 vb2cache_response  out  4  accept tag, same cycle; 0 = not accepted, cache retries.
REQ-007 vb2cache_tag  out  4  completing tag; 0 = none.
REQ-008 vb2cache_data  out  DATA_LENGTH  load data qualified by vb2cache_tag.
REQ-009 vb2mem_command / vb2mem_address / vb2mem_data  out  2 / XLEN / DATA_LENGTH  request to dmem.
REQ-010 mem2vb_response / mem2vb_tag / mem2vb_data  in  4 / 4 / DATA_LENGTH  dmem accept, completion, data.
REQ-011 vb_hit_counter / vb_miss_counter  out  integer  load hit/miss counts.
REQ-012 Parameter VB_ENTRIES, default 4: buffer depth. Parameter CQ_DEPTH, default 4: completion-queue depth.

Function
REQ-013 Buffer: VB_ENTRIES fully associative entries {valid, key, data}; FIFO order; head = oldest.
REQ-014 dmem issues tags 1..14; VB_TAG = 15 is reserved for buffer-sourced responses.
REQ-015 Load, key hit, CQ count < 3: response = VB_TAG; enqueue {VB_TAG, entry data}; entry retained; hit counter +1; no dmem request.
REQ-016 Load, key hit, CQ count >= 3: response = 0; no state change; counters unchanged.
REQ-017 Load miss: forward command/address to dmem that cycle; response = mem2vb_response; miss counter +1 only if response != 0.
REQ-018 Store, key hit: overwrite data in place; response = VB_TAG; FIFO order unchanged; accepted even when full.
REQ-019 Store miss, not full: allocate at tail; response = VB_TAG; no completion tag.
REQ-020 Store miss, full: response = 0; same cycle drive head entry to dmem as BUS_STORE; if mem2vb_response != 0, pop head.
REQ-021 Idle cycle (command BUS_NONE), buffer non-empty: drive head to dmem as BUS_STORE; pop on mem2vb_response != 0.
REQ-022 At most one dmem request per cycle; otherwise vb2mem_command = BUS_NONE.
REQ-023 Completion queue (CQ): every mem2vb_tag != 0 is enqueued with mem2vb_data; when a hit enqueues in the same cycle, the dmem entry goes first.
REQ-024 Outputs vb2cache_tag/data are the registered CQ head; tag 0 when CQ is empty. One entry is dequeued per cycle.
REQ-025 Latency: hit data appears 1 cycle after accept; dmem completions appear 1 cycle after mem2vb_tag, or later if queued behind earlier entries.
REQ-026 The CQ never overflows; REQ-016 guarantees this.
REQ-027 Full = all entries valid; empty = none valid; head/tail pointers wrap modulo VB_ENTRIES.

Reset
REQ-028 rst clears all entry valids, FIFO pointers, the CQ and both counters.
REQ-029 Reset values: vb2cache_response/tag/data = 0; vb2mem_command = BUS_NONE; address and data = 0.
REQ-030 A reset asserted during a drain discards buffered lines with no writeback; no dmem request in the reset cycle.

Structure
REQ-031 VB_TAG, VB_ENTRIES default, CQ_DEPTH default and the line-key width belong in the shared package; BUS_* and MEM_SIZE come from the existing package.
REQ-032 One sub-module: vb_completion_queue, a parameterised synchronous FIFO with count output.
REQ-033 Instantiation point: between d_cache and dmem, replacing their direct connection.

Verification
REQ-034 Store 0x100 = 0xAA…, then load 0x100 -> response 15 same cycle; next cycle tag 15, data 0xAA…; hit counter 1; no dmem request.
REQ-035 Fill 4 stores (0x0, 0x8, 0x10, 0x18), then store 0x20 -> response 0; dmem sees BUS_STORE 0x0; retry accepted once dmem accepts; load 0x0 then misses and is forwarded.
REQ-036 Store 0x8 twice (0x11…, then 0x22…) -> one entry; load returns 0x22….
REQ-037 dmem completion tag 3 and a hit in the same cycle -> tag 3 output first, tag 15 on the next cycle.
REQ-038 Hold CQ at 3 entries, then load hit -> response 0; after the CQ drains, the retry gets response 15.
REQ-039 Reset mid-drain with 2 entries buffered -> outputs 0/BUS_NONE; a following load to a drained address is forwarded to dmem.
